// File: rtl/tangram_pkg.sv
// Shared constants and types for the tangram key front end.
// Key indices, piece count and the step generator state encoding.
package tangram_pkg;

  localparam int NUM_PIECES = 7;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int KEY_ROT  = 4;
  localparam int KEY_NEXT = 5;
  localparam int KEY_DIST = 6;
  localparam int NUM_KEYS = 7;

  localparam logic [2:0] CMD_ROT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_GAP,
    ST_HOLD
  } step_st_e;

  // up > down > left > right > rotate
  function automatic logic [2:0] pick_cmd(
    input logic [4:0] keys
  );
    if (keys[DIR_UP])         return 3'(DIR_UP);
    else if (keys[DIR_DOWN])  return 3'(DIR_DOWN);
    else if (keys[DIR_LEFT])  return 3'(DIR_LEFT);
    else if (keys[DIR_RIGHT]) return 3'(DIR_RIGHT);
    else                      return CMD_ROT;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// Emits the debounced level and a one-cycle pulse on its rising edge.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/key_command.sv
// Turns raw keypad inputs into timed step commands with auto-repeat,
// a piece selector and a scramble pulse.
module key_command
  import tangram_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 400000,
  parameter int REPEAT_DELAY  = 16000000,
  parameter int REPEAT_PERIOD = 4000000,
  parameter int STEP_LEN      = 600,
  parameter int NUM_PIECES    = tangram_pkg::NUM_PIECES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            btn_dir,
  input  logic                  btn_rot,
  input  logic                  btn_next,
  input  logic                  btn_dist,
  output logic [3:0]            move,
  output logic                  rotate,
  output logic [NUM_PIECES-1:0] select,
  output logic [2:0]            sel_idx,
  output logic                  disturb
);

  localparam int SW = $clog2(STEP_LEN + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_LEN - 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
  localparam logic [2:0]    SEL_LAST  = 3'(NUM_PIECES - 1);

  logic [NUM_KEYS-1:0] raw, lvl, rise;
  logic                unused_keys;

  assign raw = {btn_dist, btn_next, btn_rot, btn_dir};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw[i]),
      .level_o(lvl[i]),
      .rise_o (rise[i])
    );
  end

  assign unused_keys = ^{lvl[KEY_DIST:KEY_NEXT], rise[KEY_ROT:0]};

  step_st_e      state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic [SW-1:0] step_q, step_d;
  logic          gap_q, gap_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [2:0]    sel_q, sel_d;
  logic          held;
  logic [RW-1:0] rep_due;

  assign held    = lvl[cmd_q];
  assign rep_due = first_q ? REP_FIRST : REP_NEXT;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    first_d = first_q;
    step_d  = step_q;
    gap_d   = gap_q;
    rep_d   = (&rep_q) ? rep_q : rep_q + RW'(1);
    sel_d   = sel_q;

    if (rise[KEY_NEXT])
      sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;

    // scramble overrides whatever the step generator is doing
    if (rise[KEY_DIST]) begin
      state_d = ST_GAP;
      gap_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|lvl[KEY_ROT:0]) begin
            cmd_d   = pick_cmd(lvl[KEY_ROT:0]);
            valid_d = 1'b1;
            first_d = 1'b1;
            step_d  = '0;
            rep_d   = '0;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (rise[KEY_NEXT] || step_q == STEP_LAST) begin
            gap_d   = 1'b0;
            state_d = ST_GAP;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        ST_GAP: begin
          if (!gap_q) begin
            gap_d = 1'b1;
          end else if (valid_q && held) begin
            state_d = ST_HOLD;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!held) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else if (rep_q >= rep_due) begin
            first_d = 1'b0;
            step_d  = '0;
            rep_d   = '0;
            state_d = ST_STEP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      step_q  <= '0;
      gap_q   <= 1'b0;
      rep_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      first_q <= first_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    move = '0;
    if (state_q == ST_STEP && cmd_q != CMD_ROT)
      move[cmd_q[1:0]] = 1'b1;
  end

  assign rotate  = (state_q == ST_STEP) && (cmd_q == CMD_ROT);
  assign select  = NUM_PIECES'(1) << sel_q;
  assign sel_idx = sel_q;
  assign disturb = rise[KEY_DIST];

endmodule

// File: tb/tb_key_command.sv
// Bench for key_command: directed scenarios plus random key traffic,
// every cycle compared with a timeline-based reference model.
module tb_key_command;

  localparam int DEB = 4;
  localparam int RD  = 40;
  localparam int RP  = 20;
  localparam int SL  = 8;
  localparam int NP  = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    btn_dir;
  logic          btn_rot, btn_next, btn_dist;
  logic [3:0]    move;
  logic          rotate;
  logic [NP-1:0] select;
  logic [2:0]    sel_idx;
  logic          disturb;

  always #5 clk = ~clk;

  key_command #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .STEP_LEN     (SL),
    .NUM_PIECES   (NP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_dir (btn_dir),
    .btn_rot (btn_rot),
    .btn_next(btn_next),
    .btn_dist(btn_dist),
    .move    (move),
    .rotate  (rotate),
    .select  (select),
    .sel_idx (sel_idx),
    .disturb (disturb)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  logic [DEB+1:0] hist [7];
  logic [6:0]     m_lvl, m_rise;
  int m_step_left, m_gap_left, m_cmd, m_sel, m_start, m_e;
  bit m_hold, m_valid, m_first;

  // observation counters
  int obs_mv [4];
  int obs_rot, obs_dist;
  int starts3 [$];
  logic [3:0] prev_move;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 7; k++) hist[k] = '0;
    m_lvl = '0;
    m_rise = '0;
    m_step_left = 0;
    m_gap_left = 0;
    m_cmd = 0;
    m_sel = 0;
    m_start = 0;
    m_hold = 0;
    m_valid = 0;
    m_first = 0;
  endtask

  task automatic model_edge();
    logic [6:0] raw, nl, nr;
    bit d;
    raw = {btn_dist, btn_next, btn_rot, btn_dir};
    if (!reset) begin
      model_clear();
    end else begin
      if (m_rise[6]) begin
        m_step_left = 0;
        m_hold = 0;
        m_gap_left = 2;
      end else if (m_step_left > 0) begin
        if (m_rise[5]) m_step_left = 0;
        else m_step_left--;
        if (m_step_left == 0) m_gap_left = 2;
      end else if (m_gap_left > 0) begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          if (m_valid && m_lvl[m_cmd]) m_hold = 1;
          else m_valid = 0;
        end
      end else if (m_hold) begin
        if (!m_lvl[m_cmd]) begin
          m_hold = 0;
          m_valid = 0;
        end else if (m_e - m_start >= (m_first ? RD : RP)) begin
          m_hold = 0;
          m_first = 0;
          m_step_left = SL;
          m_start = m_e;
        end
      end else begin
        for (int k = 4; k >= 0; k--) begin
          if (m_lvl[k]) begin
            m_cmd = k;
            m_valid = 1;
            m_first = 1;
            m_step_left = SL;
            m_start = m_e;
          end
        end
      end
      if (m_rise[5]) m_sel = (m_sel + 1) % NP;
      for (int k = 0; k < 7; k++) begin
        d = 1;
        for (int j = 1; j <= DEB; j++)
          if (hist[k][j] == m_lvl[k]) d = 0;
        nl[k] = d ? ~m_lvl[k] : m_lvl[k];
        nr[k] = d & ~m_lvl[k];
        hist[k] = {hist[k][DEB:0], raw[k]};
      end
      m_lvl = nl;
      m_rise = nr;
    end
    m_e++;
  endtask

  task automatic check_outputs();
    logic [3:0] em;
    logic er;
    em = (m_step_left > 0 && m_cmd < 4) ? 4'(1 << m_cmd) : 4'h0;
    er = (m_step_left > 0 && m_cmd == 4);
    chk("outputs",
        32'({move, rotate, disturb, sel_idx, select}),
        32'({em, er, m_rise[6], 3'(m_sel), 7'(1 << m_sel)}));
    chk("onehot", 32'($countones({move, rotate}) <= 1), 32'd1);
  endtask

  task automatic observe();
    for (int i = 0; i < 4; i++) if (move[i]) obs_mv[i]++;
    if (rotate) obs_rot++;
    if (disturb) obs_dist++;
    if (move[3] && !prev_move[3]) starts3.push_back(cyc);
    prev_move = move;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) obs_mv[i] = 0;
    obs_rot = 0;
    obs_dist = 0;
    starts3.delete();
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(negedge clk);
      cyc++;
      check_outputs();
      observe();
    end
  endtask

  task automatic wait_move(input int maxc);
    int n;
    n = 0;
    while (move == 4'h0 && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_move", 32'(move != 4'h0), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    btn_dir = '0;
    btn_rot = 0;
    btn_next = 0;
    btn_dist = 0;
    prev_move = '0;
    m_e = 0;
    model_clear();
    clear_obs();

    tick(3);
    chk("reset_move", 32'({move, rotate, disturb}), 32'd0);
    chk("reset_sel", 32'({sel_idx, select}), 32'({3'd0, 7'd1}));
    reset = 1'b1;
    tick(5);

    // short glitch must be filtered
    btn_dir[2] = 1;
    tick(3);
    btn_dir[2] = 0;
    tick(20);
    chk("glitch_left", 32'(obs_mv[2]), 32'd0);

    // single short press: one step, no repeat
    clear_obs();
    btn_dir[0] = 1;
    tick(10);
    btn_dir[0] = 0;
    tick(60);
    chk("up_len", 32'(obs_mv[0]), 32'd8);

    // long hold: first repeat after 40, then every 20
    clear_obs();
    btn_dir[3] = 1;
    tick(200);
    btn_dir[3] = 0;
    tick(60);
    chk("right_steps", 32'(starts3.size()), 32'd9);
    chk("right_len", 32'(obs_mv[3]), 32'd72);
    if (starts3.size() >= 3) begin
      chk("right_first_rep", 32'(starts3[1] - starts3[0]), 32'd40);
      chk("right_next_rep", 32'(starts3[2] - starts3[1]), 32'd20);
    end

    // up beats rotate
    clear_obs();
    btn_dir[0] = 1;
    btn_rot = 1;
    tick(20);
    btn_dir[0] = 0;
    btn_rot = 0;
    tick(40);
    chk("prio_rot", 32'(obs_rot), 32'd0);
    chk("prio_up", 32'(obs_mv[0]), 32'd8);

    // seven selector presses from reset
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      btn_next = 1;
      tick(8);
      btn_next = 0;
      tick(8);
      chk("sel_idx", 32'(sel_idx), 32'(i % NP));
      chk("select", 32'(select), 32'(1 << (i % NP)));
    end

    // selector press aborts a running step
    clear_obs();
    btn_dir[0] = 1;
    wait_move(20);
    btn_next = 1;
    tick(10);
    btn_next = 0;
    btn_dir[0] = 0;
    tick(60);
    chk("abort_sel", 32'(sel_idx), 32'd1);

    // held scramble key: a single pulse
    clear_obs();
    btn_dist = 1;
    tick(100);
    btn_dist = 0;
    tick(20);
    chk("dist_pulses", 32'(obs_dist), 32'd1);

    // reset in the middle of a step
    btn_dir[1] = 1;
    wait_move(20);
    reset = 1'b0;
    tick();
    chk("rst_mid_move", 32'({move, rotate}), 32'd0);
    chk("rst_mid_sel", 32'(select), 32'd1);
    tick(2);
    reset = 1'b1;
    tick(30);
    btn_dir[1] = 0;
    tick(30);

    // random key traffic
    for (int s = 0; s < 120; s++) begin
      {btn_dist, btn_next, btn_rot, btn_dir} = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 29) == 0) reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick($urandom_range(1, 50));
    end
    {btn_dist, btn_next, btn_rot, btn_dir} = '0;
    tick(60);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
